// File: rtl/kpad_pkg.sv
// Shared definitions for the 4x3 keypad scanner: FSM states, scan classes
// and the row/column to key-code map.
package kpad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 3;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned ROW_W    = 2;

    localparam logic [CODE_W-1:0] KEY_STAR = 4'd10;
    localparam logic [CODE_W-1:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SC_NONE   = 2'd0,
        SC_SINGLE = 2'd1,
        SC_MULTI  = 2'd2
    } scan_class_t;

    // Phone-style layout: 1-2-3 / 4-5-6 / 7-8-9 / *-0-#
    function automatic logic [CODE_W-1:0] key_map(input logic [ROW_W-1:0] row,
                                                  input logic [1:0]       col);
        logic [CODE_W-1:0] code;
        code = '0;
        unique case (row)
            2'd0:    code = 4'd1 + CODE_W'(col);
            2'd1:    code = 4'd4 + CODE_W'(col);
            2'd2:    code = 4'd7 + CODE_W'(col);
            default: begin
                unique case (col)
                    2'd0:    code = KEY_STAR;
                    2'd1:    code = 4'd0;
                    default: code = KEY_HASH;
                endcase
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/kpad_sync.sv
// Parameterized-width two-flop synchronizer with a programmable reset value.
module kpad_sync #(
    parameter int unsigned        WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/kpad_scan.sv
// 4x3 matrix keypad scanner: row rotation, per-scan classification,
// debounce FSM and a single-entry ready/valid key output.
module kpad_scan
    import kpad_pkg::*;
#(
    parameter int unsigned ROW_CYCLES     = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] col,
    output logic [NUM_ROWS-1:0] fil,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_down,
    output logic                overrun
);

    localparam int unsigned TMR_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ROW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [NUM_COLS-1:0] col_s;
    logic [ROW_W-1:0]    row_idx;
    logic [ROW_W-1:0]    row_nxt;
    logic [TMR_W-1:0]    row_tmr;
    logic                row_last;
    logic [NUM_KEYS-1:0] scan_map;
    logic                scan_eval;

    scan_class_t         scan_cls;
    logic [CODE_W-1:0]   scan_code;
    logic [3:0]          hits;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CODE_W-1:0]   cand;

    kpad_sync #(
        .WIDTH   (NUM_COLS),
        .RST_VAL (3'b111)
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col),
        .q     (col_s)
    );

    assign row_nxt  = row_idx + 2'd1;
    assign row_last = (row_tmr == TMR_LAST);

    // Row rotation; the settled columns are captured on the last cycle of each row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_idx   <= '0;
            row_tmr   <= '0;
            fil       <= 4'b1110;
            scan_map  <= '0;
            scan_eval <= 1'b0;
        end else begin
            scan_eval <= 1'b0;
            if (row_last) begin
                row_tmr   <= '0;
                row_idx   <= row_nxt;
                fil       <= ~(4'b0001 << row_nxt);
                scan_eval <= (row_idx == 2'd3);
                unique case (row_idx)
                    2'd0:    scan_map[2:0]   <= ~col_s;
                    2'd1:    scan_map[5:3]   <= ~col_s;
                    2'd2:    scan_map[8:6]   <= ~col_s;
                    default: scan_map[11:9]  <= ~col_s;
                endcase
            end else begin
                row_tmr <= row_tmr + TMR_W'(1);
            end
        end
    end

    // Classify the completed scan: no key, exactly one key, or several
    always_comb begin
        hits      = '0;
        scan_code = '0;
        scan_cls  = SC_NONE;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                if (scan_map[r*NUM_COLS + c]) begin
                    hits      = hits + 4'd1;
                    scan_code = key_map(ROW_W'(r), 2'(c));
                end
            end
        end
        if (hits == 4'd1) begin
            scan_cls = SC_SINGLE;
        end else if (hits > 4'd1) begin
            scan_cls = SC_MULTI;
        end
    end

    // Debounce FSM plus output handshake; a later accept overrides the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RELEASED;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (scan_eval) begin
                unique case (state)
                    ST_RELEASED: begin
                        if (scan_cls == SC_SINGLE) begin
                            cand <= scan_code;
                            if (DEBOUNCE_SCANS <= 1) begin
                                state    <= ST_PRESSED;
                                key_down <= 1'b1;
                                cnt      <= '0;
                                if (key_valid && !key_ready) begin
                                    overrun <= 1'b1;
                                end else begin
                                    key_code  <= scan_code;
                                    key_valid <= 1'b1;
                                end
                            end else begin
                                state <= ST_DEB_PRESS;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    ST_DEB_PRESS: begin
                        if (scan_cls == SC_SINGLE && scan_code == cand) begin
                            if (cnt == CNT_LAST) begin
                                state    <= ST_PRESSED;
                                key_down <= 1'b1;
                                cnt      <= '0;
                                if (key_valid && !key_ready) begin
                                    overrun <= 1'b1;
                                end else begin
                                    key_code  <= cand;
                                    key_valid <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else if (scan_cls == SC_SINGLE) begin
                            cand <= scan_code;
                            cnt  <= CNT_W'(1);
                        end else begin
                            state <= ST_RELEASED;
                            cnt   <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (scan_cls == SC_NONE) begin
                            if (DEBOUNCE_SCANS <= 1) begin
                                state    <= ST_RELEASED;
                                key_down <= 1'b0;
                                cnt      <= '0;
                            end else begin
                                state <= ST_DEB_RELEASE;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        if (scan_cls == SC_NONE) begin
                            if (cnt == CNT_LAST) begin
                                state    <= ST_RELEASED;
                                key_down <= 1'b0;
                                cnt      <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            state <= ST_PRESSED;
                            cnt   <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kpad_scan.sv
// Directed bench for kpad_scan with a behavioural keypad matrix model.
module tb_kpad_scan;

    localparam int unsigned ROW_CYCLES     = 4;
    localparam int unsigned DEBOUNCE_SCANS = 2;
    localparam int unsigned SCAN_CYCLES    = 16;

    localparam logic [11:0] KN  = 12'h000;
    localparam logic [11:0] K1  = 12'h001;
    localparam logic [11:0] K3  = 12'h004;
    localparam logic [11:0] K5  = 12'h010;
    localparam logic [11:0] K6  = 12'h020;
    localparam logic [11:0] K7  = 12'h040;
    localparam logic [11:0] K9  = 12'h100;
    localparam logic [11:0] KST = 12'h200;
    localparam logic [11:0] K0  = 12'h400;
    localparam logic [11:0] KHS = 12'h800;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  col;
    logic [3:0]  fil;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        key_down;
    logic        overrun;
    logic [11:0] contacts = '0;

    int n_cmp = 0;
    int n_err = 0;
    int ov_cycles = 0;

    typedef struct {
        logic [11:0] keys;
        logic        rdy;
        logic        kv;
        logic [3:0]  kc;
        logic        kd;
        logic        ov;
    } vec_t;

    vec_t vq[$];

    kpad_scan #(
        .ROW_CYCLES     (ROW_CYCLES),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .fil       (fil),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Closed contact pulls its column low while its row is driven low
    always_comb begin
        col = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (contacts[r*3 + c] && !fil[r]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (overrun) begin
            ov_cycles++;
        end
    end

    function automatic vec_t mk(input logic [11:0] keys, input logic rdy, input logic kv,
                                input logic [3:0] kc, input logic kd, input logic ov);
        vec_t v;
        v.keys = keys;
        v.rdy  = rdy;
        v.kv   = kv;
        v.kc   = kc;
        v.kd   = kd;
        v.ov   = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic kv, input logic [3:0] kc,
                            input logic kd, input logic ov);
        chk({tag, " key_valid"}, 32'(key_valid), 32'(kv));
        chk({tag, " key_code"},  32'(key_code),  32'(kc));
        chk({tag, " key_down"},  32'(key_down),  32'(kd));
        chk({tag, " overrun"},   32'(overrun),   32'(ov));
    endtask

    // Starts one cycle into row 0; ends just after the edge that applies this scan's evaluation
    task automatic step(input logic [11:0] keys, input logic rdy);
        contacts  = keys;
        key_ready = rdy;
        repeat (SCAN_CYCLES) @(posedge clk);
        #1;
    endtask

    initial begin
        // Single key held, bounce, overrun, multi-key, release bounce
        vq.push_back(mk(K6,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0));
        vq.push_back(mk(K6,  1'b0, 1'b1, 4'd6,  1'b1, 1'b0));
        vq.push_back(mk(K6,  1'b0, 1'b1, 4'd6,  1'b1, 1'b0));
        vq.push_back(mk(KN,  1'b1, 1'b0, 4'd6,  1'b1, 1'b0));
        vq.push_back(mk(KN,  1'b1, 1'b0, 4'd6,  1'b0, 1'b0));
        vq.push_back(mk(K0,  1'b0, 1'b0, 4'd6,  1'b0, 1'b0));
        vq.push_back(mk(KN,  1'b0, 1'b0, 4'd6,  1'b0, 1'b0));
        vq.push_back(mk(K0,  1'b0, 1'b0, 4'd6,  1'b0, 1'b0));
        vq.push_back(mk(K0,  1'b0, 1'b1, 4'd0,  1'b1, 1'b0));
        vq.push_back(mk(KN,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0));
        vq.push_back(mk(KN,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0));
        vq.push_back(mk(KST, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0));
        vq.push_back(mk(KST, 1'b0, 1'b1, 4'd10, 1'b1, 1'b0));
        vq.push_back(mk(KN,  1'b0, 1'b1, 4'd10, 1'b1, 1'b0));
        vq.push_back(mk(KN,  1'b0, 1'b1, 4'd10, 1'b0, 1'b0));
        vq.push_back(mk(KHS, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0));
        vq.push_back(mk(KHS, 1'b0, 1'b1, 4'd10, 1'b1, 1'b1));
        vq.push_back(mk(KHS, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0));
        vq.push_back(mk(KN,  1'b0, 1'b0, 4'd10, 1'b1, 1'b0));
        vq.push_back(mk(KN,  1'b0, 1'b0, 4'd10, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            vq.push_back(mk(K1 | K7, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0));
        end
        vq.push_back(mk(K9,  1'b0, 1'b0, 4'd10, 1'b0, 1'b0));
        vq.push_back(mk(K9,  1'b0, 1'b1, 4'd9,  1'b1, 1'b0));
        vq.push_back(mk(KN,  1'b1, 1'b0, 4'd9,  1'b1, 1'b0));
        vq.push_back(mk(K9,  1'b0, 1'b0, 4'd9,  1'b1, 1'b0));
        vq.push_back(mk(KN,  1'b0, 1'b0, 4'd9,  1'b1, 1'b0));
        vq.push_back(mk(KN,  1'b0, 1'b0, 4'd9,  1'b0, 1'b0));
        vq.push_back(mk(K9,  1'b0, 1'b0, 4'd9,  1'b0, 1'b0));
        vq.push_back(mk(K9,  1'b0, 1'b1, 4'd9,  1'b1, 1'b0));

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset fil", 32'(fil), 32'(4'b1110));
        chk_outs("reset", 1'b0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Row rotation: cycle k after reset drives row (k/4)%4 low
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_fil;
            exp_fil = ~(4'b0001 << ((k / ROW_CYCLES) % 4));
            chk($sformatf("fil cycle%0d", k), 32'(fil), 32'(exp_fil));
            @(posedge clk);
            #1;
        end

        foreach (vq[i]) begin
            step(vq[i].keys, vq[i].rdy);
            chk_outs($sformatf("step%0d", i), vq[i].kv, vq[i].kc, vq[i].kd, vq[i].ov);
        end
        chk("overrun cycles", 32'(ov_cycles), 32'd1);

        // Accept coinciding with a handshake loads the new code and keeps valid high
        step(KN, 1'b0);
        step(KN, 1'b0);
        chk_outs("pre-hs", 1'b1, 4'd9, 1'b0, 1'b0);
        step(K3, 1'b0);
        contacts  = K3;
        key_ready = 1'b0;
        repeat (SCAN_CYCLES - 1) @(posedge clk);
        #1;
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("hs-emit", 1'b1, 4'd3, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("hs-clear key_valid", 32'(key_valid), 32'd0);
        key_ready = 1'b0;
        repeat (SCAN_CYCLES - 1) @(posedge clk);
        #1;

        // Reset in the middle of a press debounce discards the progress
        step(KN, 1'b0);
        step(KN, 1'b0);
        chk("pre-rst key_down", 32'(key_down), 32'd0);
        step(K5, 1'b0);
        chk_outs("deb1", 1'b0, 4'd3, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst fil", 32'(fil), 32'(4'b1110));
        chk_outs("midrst", 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst fil", 32'(fil), 32'(4'b1110));
        step(K5, 1'b0);
        chk_outs("post-rst scan1", 1'b0, 4'd0, 1'b0, 1'b0);
        step(K5, 1'b0);
        chk_outs("post-rst scan2", 1'b1, 4'd5, 1'b1, 1'b0);
        chk("overrun cycles end", 32'(ov_cycles), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
